// File: rtl/ghash_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the GHASH engine.
package ghash_pkg;

    localparam int GHASH_W = 128;
    // Reduction constant in GCM bit order: bit 0 is the x^0 coefficient.
    localparam logic [0:GHASH_W-1] GHASH_R = 128'hE1000000_00000000_00000000_00000000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic int mul_cycles(input int digit);
        return GHASH_W / digit;
    endfunction

    function automatic int cnt_width(input int digit);
        return (GHASH_W / digit > 1) ? $clog2(GHASH_W / digit) : 1;
    endfunction

endpackage

// File: rtl/ghash_if.sv
// Block/handshake bundle between a GHASH sender (master) and the engine (slave).
interface ghash_if;

    logic [0:ghash_pkg::GHASH_W-1] hashkey;
    logic                          hashkey_load;
    logic                          start;
    logic [0:ghash_pkg::GHASH_W-1] data;
    logic                          valid;
    logic                          last;
    logic                          ready;
    logic [0:ghash_pkg::GHASH_W-1] tag;
    logic                          tag_valid;
    logic                          busy;

    modport master (
        output hashkey, hashkey_load, start, data, valid, last,
        input  ready, tag, tag_valid, busy
    );

    modport slave (
        input  hashkey, hashkey_load, start, data, valid, last,
        output ready, tag, tag_valid, busy
    );

endinterface

// File: rtl/gfmul_digit.sv
// Combinational DIGIT-step slice of the GF(2^128) shift-and-add multiplier.
module gfmul_digit
    import ghash_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [0:GHASH_W-1] acc,
    input  logic [0:GHASH_W-1] v,
    input  logic [0:DIGIT-1]   zbits,
    output logic [0:GHASH_W-1] acc_nxt,
    output logic [0:GHASH_W-1] v_nxt
);

    logic [0:GHASH_W-1] a;
    logic [0:GHASH_W-1] w;

    // zbits[0] is the earliest (most significant) multiplier bit of this slice.
    always_comb begin
        a = acc;
        w = v;
        for (int k = 0; k < DIGIT; k++) begin
            if (zbits[k]) a = a ^ w;
            w = (w >> 1) ^ (w[GHASH_W-1] ? GHASH_R : '0);
        end
        acc_nxt = a;
        v_nxt   = w;
    end

endmodule

// File: rtl/ghash_core.sv
// Sequential GHASH accumulator Y = (Y ^ X) * H for AES-GCM.
// Build option GHASH_COMB_MUL_EN: full 128-bit multiply in a single MUL cycle.
module ghash_core
    import ghash_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input logic     clk,
    input logic     rst_n,
    ghash_if.slave  bus
);

`ifdef GHASH_COMB_MUL_EN
    localparam int MUL_DIGIT = GHASH_W;
`else
    localparam int MUL_DIGIT = DIGIT;
`endif
    localparam int NCYC  = mul_cycles(MUL_DIGIT);
    localparam int CNT_W = cnt_width(MUL_DIGIT);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [0:GHASH_W-1] y;
    logic [0:GHASH_W-1] h;
    logic [0:GHASH_W-1] z;
    logic [0:GHASH_W-1] v;
    logic [0:GHASH_W-1] acc;
    logic [0:GHASH_W-1] acc_nxt;
    logic [0:GHASH_W-1] v_nxt;
    logic [0:GHASH_W-1] tag;
    logic               tag_valid;
    logic               last_q;
    logic               ready;
    logic               busy;
    logic               accept;
    logic               mul_done;

    gfmul_digit #(
        .DIGIT (MUL_DIGIT)
    ) u_gfmul_digit (
        .acc     (acc),
        .v       (v),
        .zbits   (z[0:MUL_DIGIT-1]),
        .acc_nxt (acc_nxt),
        .v_nxt   (v_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = MUL;
            MUL:     if (mul_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ready is gated by rst_n so the engine refuses blocks while reset is held.
    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        mul_done = 1'b0;
        case (state)
            IDLE:    ready = rst_n;
            MUL: begin
                busy     = 1'b1;
                mul_done = (cnt == CNT_W'(NCYC - 1));
            end
            default: ready = 1'b0;
        endcase
        accept = bus.valid & ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            y         <= '0;
            h         <= '0;
            z         <= '0;
            v         <= '0;
            acc       <= '0;
            tag       <= '0;
            tag_valid <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            tag_valid <= 1'b0;
            if (state == IDLE) begin
                if (bus.hashkey_load) h <= bus.hashkey;
                if (bus.start)        y <= '0;
                // Same-cycle start/key load take effect before the block is absorbed.
                if (accept) begin
                    z      <= (bus.start ? '0 : y) ^ bus.data;
                    v      <= bus.hashkey_load ? bus.hashkey : h;
                    acc    <= '0;
                    last_q <= bus.last;
                    cnt    <= '0;
                end
            end else begin
                acc <= acc_nxt;
                v   <= v_nxt;
                z   <= z << MUL_DIGIT;
                if (mul_done) begin
                    cnt <= '0;
                    y   <= acc_nxt;
                    if (last_q) begin
                        tag       <= acc_nxt;
                        tag_valid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.busy      = busy;
    assign bus.tag       = tag;
    assign bus.tag_valid = tag_valid;

endmodule
